mem_port_arb: RTL and testbench
===============================

// Module: mem_port_arb
// PURPOSE
//  Shares one memory request/response port between IFU instruction fetch and LSU data access.
//  Arbitrates requests, keeps an in-order owner tag per outstanding transaction, routes responses back.
//  Drops fetch responses made stale by a branch flush.
//  Sits between core (ifu, lsu) and the single-port memory/bus interface.
// PARAMETERS
//  OST_DEPTH  2   max outstanding memory transactions (owner FIFO depth, power of 2, >=1)
//  AW         32  address width (= `RV_PC_SIZE)
//  DW         32  data width (= `RV_IR_SIZE)
// PORTS
//  clk           in   1     clock
//  rst           in   1     async reset, active-high
//  ifu_req_vld   in   1     fetch request valid
//  ifu_req_rdy   out  1     fetch request accepted
//  ifu_req_addr  in   AW    fetch PC
//  ifu_rsp_vld   out  1     fetch response valid
//  ifu_rsp_rdy   in   1     IFU can take response
//  ifu_rsp_data  out  DW    instruction word
//  fl_vld        in   1     flush: all fetches outstanding now become stale
//  lsu_req_vld   in   1     data request valid
//  lsu_req_rdy   out  1     data request accepted
//  lsu_req_we    in   1     1 = store
//  lsu_req_addr  in   AW    data address
//  lsu_req_wdata in   DW    store data
//  lsu_req_wstrb in   DW/8  byte enables
//  lsu_rsp_vld   out  1     data response valid
//  lsu_rsp_rdy   in   1     LSU can take response
//  lsu_rsp_data  out  DW    load data (store: don't care)
//  mem_req_vld   out  1     memory request valid
//  mem_req_rdy   in   1     memory accepts request
//  mem_req_we/addr/wdata/wstrb  out  1/AW/DW/DW/8  muxed request payload
//  mem_rsp_vld   in   1     memory response valid (in request order)
//  mem_rsp_rdy   out  1     arbiter accepts response
//  mem_rsp_data  in   DW    response data
// BEHAVIOUR
//  Reset: all *_vld/*_rdy outputs 0; owner FIFO empty; last-grant pointer = IFU (LSU wins first tie).
//  Grant (combinational, same cycle): candidates = requesters with vld; none if owner FIFO full.
//   Both valid -> see CONFIGURATION. mem_req_vld = granted vld; payload muxed from granted source
//   (IFU: we=0, wstrb=0, wdata=0). Granted *_req_rdy = mem_req_rdy; loser *_req_rdy = 0.
//   mem_req_vld never depends on mem_req_rdy; grant held stable while mem_req_vld & ~mem_req_rdy.
//  Request handshake (mem_req_vld & mem_req_rdy): push {owner, drop=0}; update last-grant pointer.
//  Response: head owner selects destination; mem_rsp_rdy = head dest rdy, or 1 if head.drop.
//   Dropped head: response consumed silently, ifu_rsp_vld stays 0. Pop on mem_rsp handshake.
//   mem_rsp_vld with FIFO empty is a protocol error (assertion); response ignored, rdy = 0.
//  Latency: request 0 cycles added; response 0 cycles added (pure routing, no buffering).
//  Flush: on fl_vld set drop=1 on every valid IFU entry incl. one being popped/pushed same cycle;
//   IFU request pushed in flush cycle is also marked drop (its PC predates redirect).
//   Head response accepted in flush cycle is still suppressed (ifu_rsp_vld gated by fl_vld).
//   LSU entries unaffected.
//  Simultaneous push+pop when full: not allowed (push blocked while full, even if popping).
//  Pointer wrap: read/write pointers log2(OST_DEPTH)+1 bits, full = MSB differ & rest equal.
//  Reset mid-transaction: FIFO cleared; memory side must be reset together (no response replay).
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin — on conflict, grant the source not granted last.
//  Not defined: fixed priority — LSU always wins conflict (pointer still tracked, unused).
// STRUCTURE
//  Package mem_arb_pkg: typedef enum logic {OWN_IFU, OWN_LSU} owner_e; struct ost_ent_t {owner_e own; logic drop};
//   width constants from core/isa.svh.
//  Sub-module mem_arb_ost_fifo: OST_DEPTH x ost_ent_t, push/pop/full/empty/head, plus flush-mark input
//   that sets drop on all OWN_IFU entries.
// TESTING
//  1 IFU only, mem rdy=1, rsp 1 cycle later, addr 0x40000000 -> ifu_rsp_data = mem data, lsu_rsp_vld 0.
//  2 Both valid every cycle, RR_EN -> grants alternate LSU,IFU,LSU...; fixed -> LSU every cycle, IFU starved.
//  3 Issue 2 fetches, memory withholds rsp -> 3rd request rdy=0 (full) until first response pops.
//  4 Fetch outstanding, fl_vld pulse, then rsp 0xDEADBEEF -> mem_rsp_rdy=1, ifu_rsp_vld never 1.
//  5 Store then load to 0x80000010, responses in order -> store rsp to LSU, load data to LSU, IFU idle.
//  6 mem_req_rdy=0 for 3 cycles with both valid -> mem_req payload and grant constant until accepted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the IFU/LSU memory port arbiter.
// Width constants mirror the core's RV_PC_SIZE / RV_IR_SIZE.
package mem_arb_pkg;

  localparam int RV_PC_SIZE = 32;
  localparam int RV_IR_SIZE = 32;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  typedef struct packed {
    owner_e own;
    logic   drop;
  } ost_ent_t;

  // Grant lock: HOLD keeps the current grant while memory back-pressures it.
  typedef enum logic {
    GS_OPEN,
    GS_HOLD
  } gnt_st_e;

endpackage

// File: rtl/mem_arb_ost_fifo.sv
// In-order owner FIFO for outstanding memory transactions.
// flush_mark sets drop on every OWN_IFU entry; a same-cycle push overrides its own slot.
module mem_arb_ost_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ost_ent_t push_ent,
  input  logic     pop,
  input  logic     flush_mark,
  output logic     full,
  output logic     empty,
  output ost_ent_t head
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] FULL_XOR = PW'(1) << (PW - 1);

  ost_ent_t      ent_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_idx = (DEPTH == 1) ? '0 : wr_ptr[IW-1:0];
  assign rd_idx = (DEPTH == 1) ? '0 : rd_ptr[IW-1:0];

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);
  assign head  = ent_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '{own: OWN_IFU, drop: 1'b0};
      end
    end else begin
      if (flush_mark) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_q[i].own == OWN_IFU) ent_q[i].drop <= 1'b1;
        end
      end
      if (push && !full) begin
        ent_q[wr_idx] <= push_ent;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one memory request/response port between IFU fetch and LSU access.
// Build option MEM_ARB_RR_EN: round-robin on conflict; otherwise LSU has fixed priority.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int OST_DEPTH = 2,
  parameter int AW        = RV_PC_SIZE,
  parameter int DW        = RV_IR_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_vld,
  output logic            ifu_req_rdy,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_rsp_vld,
  input  logic            ifu_rsp_rdy,
  output logic [DW-1:0]   ifu_rsp_data,
  input  logic            fl_vld,
  input  logic            lsu_req_vld,
  output logic            lsu_req_rdy,
  input  logic            lsu_req_we,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wstrb,
  output logic            lsu_rsp_vld,
  input  logic            lsu_rsp_rdy,
  output logic [DW-1:0]   lsu_rsp_data,
  output logic            mem_req_vld,
  input  logic            mem_req_rdy,
  output logic            mem_req_we,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic            mem_rsp_vld,
  output logic            mem_rsp_rdy,
  input  logic [DW-1:0]   mem_rsp_data
);

  // Handshake rule on every port: a transfer happens in a cycle where vld and rdy
  // are both high; vld never waits on rdy, and the arbiter holds its grant and
  // payload stable while mem_req_vld is high and mem_req_rdy is low.

  gnt_st_e  gnt_st, gnt_st_nxt;
  owner_e   hold_own, last_gnt, gnt_own, arb_pick;
  logic     fifo_full, fifo_empty;
  logic     ifu_cand, lsu_cand;
  logic     req_fire, rsp_fire;
  ost_ent_t push_ent, head;

  assign ifu_cand = ifu_req_vld && !fifo_full;
  assign lsu_cand = lsu_req_vld && !fifo_full;

`ifdef MEM_ARB_RR_EN
  assign arb_pick = (last_gnt == OWN_IFU) ? OWN_LSU : OWN_IFU;
`else
  logic unused_last_gnt;
  assign arb_pick        = OWN_LSU;
  assign unused_last_gnt = last_gnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_st   <= GS_OPEN;
      hold_own <= OWN_IFU;
      last_gnt <= OWN_IFU;
    end else begin
      gnt_st   <= gnt_st_nxt;
      hold_own <= gnt_own;
      if (req_fire) last_gnt <= gnt_own;
    end
  end

  always_comb begin
    gnt_own = OWN_IFU;
    if (gnt_st == GS_HOLD)          gnt_own = hold_own;
    else if (lsu_cand && ifu_cand)  gnt_own = arb_pick;
    else if (lsu_cand)              gnt_own = OWN_LSU;
    mem_req_vld = (gnt_own == OWN_LSU) ? lsu_cand : ifu_cand;
    gnt_st_nxt  = (mem_req_vld && !mem_req_rdy) ? GS_HOLD : GS_OPEN;
  end

  always_comb begin
    mem_req_we    = 1'b0;
    mem_req_addr  = ifu_req_addr;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    if (gnt_own == OWN_LSU) begin
      mem_req_we    = lsu_req_we;
      mem_req_addr  = lsu_req_addr;
      mem_req_wdata = lsu_req_wdata;
      mem_req_wstrb = lsu_req_wstrb;
    end
  end

  assign req_fire    = mem_req_vld && mem_req_rdy;
  assign ifu_req_rdy = req_fire && (gnt_own == OWN_IFU);
  assign lsu_req_rdy = req_fire && (gnt_own == OWN_LSU);

  // A fetch issued while flushing carries a pre-redirect PC, so it is born stale.
  assign push_ent.own  = gnt_own;
  assign push_ent.drop = fl_vld && (gnt_own == OWN_IFU);

  mem_arb_ost_fifo #(
    .DEPTH(OST_DEPTH)
  ) u_ost_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_ent  (push_ent),
    .pop       (rsp_fire),
    .flush_mark(fl_vld),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_comb begin
    mem_rsp_rdy = 1'b0;
    if (!fifo_empty) begin
      if (head.drop)                mem_rsp_rdy = 1'b1;
      else if (head.own == OWN_LSU) mem_rsp_rdy = lsu_rsp_rdy;
      else                          mem_rsp_rdy = ifu_rsp_rdy;
    end
  end

  assign rsp_fire     = mem_rsp_vld && mem_rsp_rdy;
  assign ifu_rsp_vld  = mem_rsp_vld && !fifo_empty && (head.own == OWN_IFU) && !head.drop && !fl_vld;
  assign lsu_rsp_vld  = mem_rsp_vld && !fifo_empty && (head.own == OWN_LSU);
  assign ifu_rsp_data = mem_rsp_data;
  assign lsu_rsp_data = mem_rsp_data;

  // Memory must never answer with nothing outstanding.
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst) !(mem_rsp_vld && fifo_empty));

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: routing, arbitration, full blocking, flush drop, grant hold.
module tb_mem_port_arb;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ifu_req_vld = 0, ifu_req_rdy;
  logic [AW-1:0]   ifu_req_addr = '0;
  logic            ifu_rsp_vld, ifu_rsp_rdy = 0;
  logic [DW-1:0]   ifu_rsp_data;
  logic            fl_vld = 0;
  logic            lsu_req_vld = 0, lsu_req_rdy, lsu_req_we = 0;
  logic [AW-1:0]   lsu_req_addr = '0;
  logic [DW-1:0]   lsu_req_wdata = '0;
  logic [DW/8-1:0] lsu_req_wstrb = '0;
  logic            lsu_rsp_vld, lsu_rsp_rdy = 0;
  logic [DW-1:0]   lsu_rsp_data;
  logic            mem_req_vld, mem_req_rdy = 0, mem_req_we;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wstrb;
  logic            mem_rsp_vld = 0, mem_rsp_rdy;
  logic [DW-1:0]   mem_rsp_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  mem_port_arb #(.OST_DEPTH(2), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_vld(ifu_req_vld), .ifu_req_rdy(ifu_req_rdy), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_rdy(ifu_rsp_rdy), .ifu_rsp_data(ifu_rsp_data),
    .fl_vld(fl_vld),
    .lsu_req_vld(lsu_req_vld), .lsu_req_rdy(lsu_req_rdy), .lsu_req_we(lsu_req_we),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_rdy(lsu_rsp_rdy), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_data(mem_rsp_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic exp_lsu, prev_lsu;
  logic [DW-1:0] exp_d;

  initial begin
    // Reset state
    mem_req_rdy = 1'b1;
    ifu_rsp_rdy = 1'b1;
    lsu_rsp_rdy = 1'b1;
    repeat (3) tick();
    check("rst_ifu_req_rdy", ifu_req_rdy, 0);
    check("rst_lsu_req_rdy", lsu_req_rdy, 0);
    check("rst_mem_req_vld", mem_req_vld, 0);
    check("rst_mem_rsp_rdy", mem_rsp_rdy, 0);
    check("rst_ifu_rsp_vld", ifu_rsp_vld, 0);
    check("rst_lsu_rsp_vld", lsu_rsp_vld, 0);
    rst = 1'b0;
    tick();

    // 1: single fetch, response next cycle
    ifu_req_vld = 1; ifu_req_addr = 32'h4000_0000;
    #1;
    check("t1_mem_req_vld", mem_req_vld, 1);
    check("t1_mem_req_addr", mem_req_addr, 32'h4000_0000);
    check("t1_mem_req_we", mem_req_we, 0);
    check("t1_ifu_req_rdy", ifu_req_rdy, 1);
    check("t1_lsu_req_rdy", lsu_req_rdy, 0);
    tick();
    ifu_req_vld = 0; mem_rsp_vld = 1; mem_rsp_data = 32'h1234_5678;
    #1;
    check("t1_ifu_rsp_vld", ifu_rsp_vld, 1);
    check("t1_ifu_rsp_data", ifu_rsp_data, 32'h1234_5678);
    check("t1_lsu_rsp_vld", lsu_rsp_vld, 0);
    check("t1_mem_rsp_rdy", mem_rsp_rdy, 1);
    tick();
    mem_rsp_vld = 0;
    #1;
    check("t1_empty_rsp_rdy", mem_rsp_rdy, 0);

    // 2: both requesting every cycle, memory answers one cycle later
    ifu_req_vld = 1; ifu_req_addr = 32'h4000_0200;
    lsu_req_vld = 1; lsu_req_we = 0; lsu_req_addr = 32'h8000_0000;
    prev_lsu = 0;
    for (int i = 0; i < 6; i++) begin
      mem_rsp_vld  = (i > 0);
      mem_rsp_data = 32'h100 + i;
`ifdef MEM_ARB_RR_EN
      exp_lsu = (i % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      #1;
      check("t2_lsu_req_rdy", lsu_req_rdy, exp_lsu);
      check("t2_ifu_req_rdy", ifu_req_rdy, !exp_lsu);
      check("t2_mem_req_addr", mem_req_addr, exp_lsu ? 32'h8000_0000 : 32'h4000_0200);
      if (i > 0) begin
        check("t2_lsu_rsp_vld", lsu_rsp_vld, prev_lsu);
        check("t2_ifu_rsp_vld", ifu_rsp_vld, !prev_lsu);
      end
      prev_lsu = exp_lsu;
      tick();
    end
    ifu_req_vld = 0; lsu_req_vld = 0; mem_rsp_vld = 1;
    #1;
    check("t2_drain_lsu_rsp", lsu_rsp_vld, prev_lsu);
    check("t2_drain_ifu_rsp", ifu_rsp_vld, !prev_lsu);
    tick();
    mem_rsp_vld = 0;
    #1;
    check("t2_empty_rsp_rdy", mem_rsp_rdy, 0);

    // 3: two fetches fill the FIFO, third is blocked until a pop completes
    ifu_req_vld = 1; ifu_req_addr = 32'h4000_0000;
    tick();
    ifu_req_addr = 32'h4000_0004;
    tick();
    ifu_req_addr = 32'h4000_0008;
    #1;
    check("t3_full_ifu_rdy", ifu_req_rdy, 0);
    check("t3_full_mem_vld", mem_req_vld, 0);
    tick();
    check("t3_full_ifu_rdy2", ifu_req_rdy, 0);
    mem_rsp_vld = 1; mem_rsp_data = 32'h0000_0001;
    #1;
    check("t3_pop_ifu_rsp_vld", ifu_rsp_vld, 1);
    check("t3_pop_blocks_push", ifu_req_rdy, 0);
    tick();
    mem_rsp_vld = 0;
    #1;
    check("t3_after_pop_rdy", ifu_req_rdy, 1);
    tick();
    ifu_req_vld = 0;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_vld = 1; mem_rsp_data = 32'h0000_0002 + i;
      #1;
      check("t3_drain_vld", ifu_rsp_vld, 1);
      check("t3_drain_data", ifu_rsp_data, 32'h0000_0002 + i);
      tick();
    end
    mem_rsp_vld = 0;

    // 4a: flush after fetch issue, stale response swallowed
    ifu_req_vld = 1; ifu_req_addr = 32'h4000_0300;
    tick();
    ifu_req_vld = 0; fl_vld = 1;
    tick();
    fl_vld = 0; ifu_rsp_rdy = 0; mem_rsp_vld = 1; mem_rsp_data = 32'hDEAD_BEEF;
    #1;
    check("t4a_mem_rsp_rdy", mem_rsp_rdy, 1);
    check("t4a_ifu_rsp_vld", ifu_rsp_vld, 0);
    tick();
    mem_rsp_vld = 0; ifu_rsp_rdy = 1;
    #1;
    check("t4a_popped", mem_rsp_rdy, 0);

    // 4b: flush in the same cycle the head response arrives
    ifu_req_vld = 1;
    tick();
    ifu_req_vld = 0; fl_vld = 1; mem_rsp_vld = 1;
    #1;
    check("t4b_ifu_rsp_vld", ifu_rsp_vld, 0);
    check("t4b_mem_rsp_rdy", mem_rsp_rdy, 1);
    tick();
    fl_vld = 0; mem_rsp_vld = 0;
    #1;
    check("t4b_popped", mem_rsp_rdy, 0);

    // 4c: fetch issued during flush is stale
    ifu_req_vld = 1; fl_vld = 1;
    #1;
    check("t4c_ifu_req_rdy", ifu_req_rdy, 1);
    tick();
    ifu_req_vld = 0; fl_vld = 0; ifu_rsp_rdy = 0; mem_rsp_vld = 1;
    #1;
    check("t4c_mem_rsp_rdy", mem_rsp_rdy, 1);
    check("t4c_ifu_rsp_vld", ifu_rsp_vld, 0);
    tick();
    mem_rsp_vld = 0; ifu_rsp_rdy = 1;

    // 4d: LSU entry survives a flush
    lsu_req_vld = 1; lsu_req_we = 0; lsu_req_addr = 32'h8000_0040;
    tick();
    lsu_req_vld = 0; fl_vld = 1;
    tick();
    fl_vld = 0; mem_rsp_vld = 1; mem_rsp_data = 32'h55AA_55AA;
    #1;
    check("t4d_lsu_rsp_vld", lsu_rsp_vld, 1);
    check("t4d_lsu_rsp_data", lsu_rsp_data, 32'h55AA_55AA);
    tick();
    mem_rsp_vld = 0;

    // 5: store then load to one address, in-order responses to LSU
    lsu_req_vld = 1; lsu_req_we = 1; lsu_req_addr = 32'h8000_0010;
    lsu_req_wdata = 32'hCAFE_F00D; lsu_req_wstrb = 4'hF;
    #1;
    check("t5_st_we", mem_req_we, 1);
    check("t5_st_addr", mem_req_addr, 32'h8000_0010);
    check("t5_st_wdata", mem_req_wdata, 32'hCAFE_F00D);
    check("t5_st_wstrb", mem_req_wstrb, 4'hF);
    exp_q.push_back(32'h0000_0000);
    tick();
    lsu_req_we = 0;
    #1;
    check("t5_ld_we", mem_req_we, 0);
    check("t5_ld_rdy", lsu_req_rdy, 1);
    exp_q.push_back(32'hA5A5_A5A5);
    tick();
    lsu_req_vld = 0;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_vld = 1; mem_rsp_data = (i == 0) ? 32'h0000_0000 : 32'hA5A5_A5A5;
      #1;
      check("t5_lsu_rsp_vld", lsu_rsp_vld, 1);
      check("t5_ifu_rsp_vld", ifu_rsp_vld, 0);
      if (exp_q.size() == 0) begin
        check("t5_exp_q_underflow", 1, 0);
      end else begin
        exp_d = exp_q.pop_front();
        check("t5_lsu_rsp_data", lsu_rsp_data, exp_d);
      end
      tick();
    end
    mem_rsp_vld = 0;

    // 6: back-pressure holds the grant and payload even when LSU joins
    mem_req_rdy = 0; ifu_req_vld = 1; ifu_req_addr = 32'h4000_0100;
    #1;
    check("t6_stall_vld", mem_req_vld, 1);
    check("t6_stall_ifu_rdy", ifu_req_rdy, 0);
    tick();
    lsu_req_vld = 1; lsu_req_we = 1; lsu_req_addr = 32'h8000_0020;
    lsu_req_wdata = 32'h1122_3344; lsu_req_wstrb = 4'h3;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t6_hold_vld", mem_req_vld, 1);
      check("t6_hold_addr", mem_req_addr, 32'h4000_0100);
      check("t6_hold_we", mem_req_we, 0);
      check("t6_hold_wstrb", mem_req_wstrb, 4'h0);
      check("t6_hold_lsu_rdy", lsu_req_rdy, 0);
      tick();
    end
    mem_req_rdy = 1;
    #1;
    check("t6_accept_ifu_rdy", ifu_req_rdy, 1);
    check("t6_accept_addr", mem_req_addr, 32'h4000_0100);
    tick();
    ifu_req_vld = 0;
    #1;
    check("t6_lsu_rdy", lsu_req_rdy, 1);
    check("t6_lsu_we", mem_req_we, 1);
    check("t6_lsu_wdata", mem_req_wdata, 32'h1122_3344);
    check("t6_lsu_wstrb", mem_req_wstrb, 4'h3);
    tick();
    lsu_req_vld = 0; mem_rsp_vld = 1; mem_rsp_data = 32'h0BAD_F00D;
    #1;
    check("t6_ifu_rsp_vld", ifu_rsp_vld, 1);
    tick();
    #1;
    check("t6_lsu_rsp_vld", lsu_rsp_vld, 1);
    tick();
    mem_rsp_vld = 0;
    #1;
    check("t6_empty_rsp_rdy", mem_rsp_rdy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
